// File: rtl/cyclotron_pkg.sv
// Shared types for the cyclotron instruction buffer: the decoded entry layout
// and the default sizing constants it is built from.
package cyclotron_pkg;

  localparam int IBUF_ARCH_LEN   = 32;
  localparam int IBUF_NUM_LANES  = 16;
  localparam int IBUF_INST_BITS  = 64;
  localparam int IBUF_DEPTH      = 4;

  localparam int OP_BITS         = 9;
  localparam int REG_BITS        = 8;
  localparam int IMM32_BITS      = 32;
  localparam int IMM24_BITS      = 24;
  localparam int CSR_IMM_BITS    = 8;
  localparam int F3_BITS         = 3;
  localparam int F7_BITS         = 7;
  localparam int PRED_BITS       = 4;

  typedef struct packed {
    logic [IBUF_ARCH_LEN-1:0]  pc;
    logic [OP_BITS-1:0]        op;
    logic [REG_BITS-1:0]       rd;
    logic [REG_BITS-1:0]       rs1;
    logic [REG_BITS-1:0]       rs2;
    logic [REG_BITS-1:0]       rs3;
    logic [IMM32_BITS-1:0]     imm32;
    logic [IMM24_BITS-1:0]     imm24;
    logic [CSR_IMM_BITS-1:0]   csr_imm;
    logic [F3_BITS-1:0]        f3;
    logic [F7_BITS-1:0]        f7;
    logic [PRED_BITS-1:0]      pred;
    logic [IBUF_NUM_LANES-1:0] tmask;
    logic [IBUF_INST_BITS-1:0] raw;
  } ibuf_entry_t;

  localparam int IBUF_ENTRY_BITS = $bits(ibuf_entry_t);

endpackage

// File: rtl/cyclotron_ibuf_fifo.sv
// Single-warp circular FIFO with count, head output and a flush that wins over
// any concurrent push or pop.
module cyclotron_ibuf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic                         full,
  output logic                         valid,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic                push_fire;
  logic                pop_fire;

  assign full      = (count == CNT_BITS'(DEPTH));
  assign valid     = (count != '0);
  assign head      = mem[rd_ptr];
  assign push_fire = push && !full && !flush;
  assign pop_fire  = pop && valid;

  // Storage is deliberately left unreset; valid gates every read.
  always_ff @(posedge clock) begin
    if (push_fire) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + CNT_BITS'(1);
        2'b01:   count <= count - CNT_BITS'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cyclotron_ibuffer.sv
// Per-warp instruction buffer: one shared enqueue port steered by warp id,
// independent per-warp dequeue ports, and a drained/finished indicator.
module cyclotron_ibuffer
  import cyclotron_pkg::*;
#(
  parameter int NUM_WARPS = 8,
  parameter int NUM_LANES = 16,
  parameter int ARCH_LEN  = 32,
  parameter int INST_BITS = 64,
  parameter int DEPTH     = 4,
  localparam int WID_BITS   = $clog2(NUM_WARPS),
  localparam int CNT_BITS   = $clog2(DEPTH + 1),
  localparam int ENTRY_BITS = $bits(ibuf_entry_t)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enq_valid,
  output logic                            enq_ready,
  input  logic [WID_BITS-1:0]             enq_wid,
  input  logic [ENTRY_BITS-1:0]           enq_bits,
  input  logic [NUM_WARPS-1:0]            flush,
  input  logic [NUM_WARPS-1:0]            deq_ready,
  output logic [NUM_WARPS-1:0]            deq_valid,
  output logic [NUM_WARPS*ENTRY_BITS-1:0] deq_bits,
  output logic [NUM_WARPS*CNT_BITS-1:0]   count,
  input  logic                            src_finished,
  output logic                            finished
);

  // The entry layout lives in the package, so the lane/width parameters must agree with it.
  if (NUM_LANES != IBUF_NUM_LANES || ARCH_LEN != IBUF_ARCH_LEN ||
      INST_BITS != IBUF_INST_BITS) begin : g_param_check
    $error("cyclotron_ibuffer: entry widths disagree with cyclotron_pkg");
  end

  logic [NUM_WARPS-1:0] full_vec;
  logic                 enq_fire;

  assign enq_ready = !full_vec[enq_wid] && !flush[enq_wid];
  assign enq_fire  = enq_valid && enq_ready;

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
    cyclotron_ibuf_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_BITS)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (enq_fire && (enq_wid == WID_BITS'(g))),
      .push_data (enq_bits),
      .pop       (deq_ready[g]),
      .flush     (flush[g]),
      .full      (full_vec[g]),
      .valid     (deq_valid[g]),
      .head      (deq_bits[ENTRY_BITS*g +: ENTRY_BITS]),
      .count     (count[CNT_BITS*g +: CNT_BITS])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      finished <= 1'b0;
    end else begin
      finished <= src_finished && (deq_valid == '0);
    end
  end

endmodule

// File: tb/tb_cyclotron_ibuffer.sv
// Self-checking bench for cyclotron_ibuffer: expected entries are queued when
// pushed and compared against the head as each pop handshake occurs.
module tb_cyclotron_ibuffer;
  import cyclotron_pkg::*;

  localparam int NUM_WARPS  = 8;
  localparam int DEPTH      = 4;
  localparam int WID_BITS   = 3;
  localparam int CNT_BITS   = 3;
  localparam int ENTRY_BITS = $bits(ibuf_entry_t);

  logic                            clock = 1'b0;
  logic                            reset;
  logic                            enq_valid;
  logic                            enq_ready;
  logic [WID_BITS-1:0]             enq_wid;
  logic [ENTRY_BITS-1:0]           enq_bits;
  logic [NUM_WARPS-1:0]            flush;
  logic [NUM_WARPS-1:0]            deq_ready;
  logic [NUM_WARPS-1:0]            deq_valid;
  logic [NUM_WARPS*ENTRY_BITS-1:0] deq_bits;
  logic [NUM_WARPS*CNT_BITS-1:0]   count;
  logic                            src_finished;
  logic                            finished;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];

  cyclotron_ibuffer dut (
    .clock        (clock),
    .reset        (reset),
    .enq_valid    (enq_valid),
    .enq_ready    (enq_ready),
    .enq_wid      (enq_wid),
    .enq_bits     (enq_bits),
    .flush        (flush),
    .deq_ready    (deq_ready),
    .deq_valid    (deq_valid),
    .deq_bits     (deq_bits),
    .count        (count),
    .src_finished (src_finished),
    .finished     (finished)
  );

  always #5 clock = ~clock;

  function automatic ibuf_entry_t make_entry(input logic [31:0] pc);
    ibuf_entry_t e;
    e       = '0;
    e.pc    = pc;
    e.op    = pc[8:0];
    e.rd    = pc[7:0] ^ 8'h5a;
    e.imm32 = ~pc;
    e.tmask = 16'hffff ^ pc[15:0];
    e.raw   = {pc, ~pc};
    return e;
  endfunction

  function automatic ibuf_entry_t head_of(input int g);
    return ibuf_entry_t'(deq_bits[ENTRY_BITS*g +: ENTRY_BITS]);
  endfunction

  function automatic logic [CNT_BITS-1:0] cnt_of(input int g);
    return count[CNT_BITS*g +: CNT_BITS];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input int wid, input logic [31:0] pc);
    enq_valid = 1'b1;
    enq_wid   = WID_BITS'(wid);
    enq_bits  = make_entry(pc);
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    total++; if (deq_valid !== 8'h00) $display("FAIL reset_valid: got %h expected %h", deq_valid, 8'h00); else passed++;
    total++; if (count !== 24'h0) $display("FAIL reset_count: got %h expected %h", count, 24'h0); else passed++;
    total++; if (finished !== 1'b0) $display("FAIL reset_finished: got %b expected 0", finished); else passed++;
    total++; if (enq_ready !== 1'b1) $display("FAIL reset_enq_ready: got %b expected 1", enq_ready); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_push();
    enq_valid = 1'b1;
    enq_wid   = 3'd3;
    enq_bits  = make_entry(32'h1000);
    exp_q.push_back(32'h1000);
    #1;
    total++; if (deq_valid !== 8'h00) $display("FAIL push_no_bypass: got %h expected %h", deq_valid, 8'h00); else passed++;
    tick();
    enq_valid = 1'b0;
    total++; if (deq_valid !== 8'h08) $display("FAIL push_valid: got %h expected %h", deq_valid, 8'h08); else passed++;
    total++; if (count !== (24'd1 << 9)) $display("FAIL push_count: got %h expected %h", count, 24'd1 << 9); else passed++;
    deq_ready = 8'h08;
    total++; if (head_of(3) !== make_entry(exp_q[0])) $display("FAIL push_data: got pc %h expected %h", head_of(3).pc, exp_q[0]); else passed++;
    void'(exp_q.pop_front());
    tick();
    deq_ready = 8'h00;
    total++; if (count !== 24'h0) $display("FAIL push_pop_count: got %h expected %h", count, 24'h0); else passed++;
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      push_one(0, 32'h2000 + i);
      exp_q.push_back(32'h2000 + i);
    end
    total++; if (cnt_of(0) !== 3'd4) $display("FAIL full_count: got %0d expected 4", cnt_of(0)); else passed++;
    enq_wid = 3'd0; #1;
    total++; if (enq_ready !== 1'b0) $display("FAIL full_ready_w0: got %b expected 0", enq_ready); else passed++;
    enq_wid = 3'd1; #1;
    total++; if (enq_ready !== 1'b1) $display("FAIL full_ready_w1: got %b expected 1", enq_ready); else passed++;
    enq_wid   = 3'd0;
    enq_valid = 1'b1;
    enq_bits  = make_entry(32'hdead);
    deq_ready = 8'h01;
    #1;
    total++; if (enq_ready !== 1'b0) $display("FAIL full_pop_push_ready: got %b expected 0", enq_ready); else passed++;
    total++; if (head_of(0) !== make_entry(exp_q[0])) $display("FAIL full_head: got pc %h expected %h", head_of(0).pc, exp_q[0]); else passed++;
    void'(exp_q.pop_front());
    tick();
    enq_valid = 1'b0;
    total++; if (cnt_of(0) !== 3'd3) $display("FAIL full_after_pop: got %0d expected 3", cnt_of(0)); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (head_of(0) !== make_entry(exp_q[0])) $display("FAIL full_drain: got pc %h expected %h", head_of(0).pc, exp_q[0]); else passed++;
      void'(exp_q.pop_front());
      tick();
    end
    deq_ready = 8'h00;
    total++; if (count !== 24'h0) $display("FAIL full_drained: got %h expected %h", count, 24'h0); else passed++;
  endtask

  task automatic test_wrap();
    int sent = 0;
    int received = 0;
    int max_cnt = 0;
    deq_ready = 8'h20;
    enq_wid   = 3'd5;
    for (int cyc = 0; cyc < 40 && received < 10; cyc++) begin
      if (deq_valid[5]) begin
        total++; if (head_of(5) !== make_entry(exp_q[0])) $display("FAIL wrap_order: got pc %h expected %h", head_of(5).pc, exp_q[0]); else passed++;
        void'(exp_q.pop_front());
        received++;
      end
      enq_valid = (sent < 10);
      enq_bits  = make_entry(32'(sent));
      #1;
      if (enq_valid && enq_ready) begin
        exp_q.push_back(32'(sent));
        sent++;
      end
      tick();
      if (int'(cnt_of(5)) > max_cnt) max_cnt = int'(cnt_of(5));
    end
    enq_valid = 1'b0;
    deq_ready = 8'h00;
    total++; if (received !== 10) $display("FAIL wrap_received: got %0d expected 10", received); else passed++;
    total++; if (max_cnt > DEPTH) $display("FAIL wrap_max_count: got %0d expected at most %0d", max_cnt, DEPTH); else passed++;
  endtask

  task automatic test_flush();
    push_one(1, 32'h100); exp_q.push_back(32'h100);
    push_one(1, 32'h101); exp_q.push_back(32'h101);
    for (int i = 0; i < 3; i++) push_one(2, 32'h200 + i);
    total++; if (cnt_of(2) !== 3'd3) $display("FAIL flush_pre_count: got %0d expected 3", cnt_of(2)); else passed++;
    flush     = 8'h04;
    enq_valid = 1'b1;
    enq_wid   = 3'd2;
    enq_bits  = make_entry(32'h222);
    #1;
    total++; if (enq_ready !== 1'b0) $display("FAIL flush_enq_ready: got %b expected 0", enq_ready); else passed++;
    tick();
    flush     = 8'h00;
    enq_valid = 1'b0;
    total++; if (cnt_of(2) !== 3'd0) $display("FAIL flush_count: got %0d expected 0", cnt_of(2)); else passed++;
    total++; if (cnt_of(1) !== 3'd2) $display("FAIL flush_other_count: got %0d expected 2", cnt_of(1)); else passed++;
    total++; if (deq_valid !== 8'h02) $display("FAIL flush_valid: got %h expected %h", deq_valid, 8'h02); else passed++;
    push_one(2, 32'h333);
    total++; if (head_of(2) !== make_entry(32'h333)) $display("FAIL flush_refill: got pc %h expected %h", head_of(2).pc, 32'h333); else passed++;
    deq_ready = 8'h06;
    total++; if (head_of(1) !== make_entry(exp_q[0])) $display("FAIL flush_w1_data: got pc %h expected %h", head_of(1).pc, exp_q[0]); else passed++;
    void'(exp_q.pop_front());
    tick();
    deq_ready = 8'h02;
    total++; if (head_of(1) !== make_entry(exp_q[0])) $display("FAIL flush_w1_data: got pc %h expected %h", head_of(1).pc, exp_q[0]); else passed++;
    void'(exp_q.pop_front());
    tick();
    deq_ready = 8'h00;
    total++; if (count !== 24'h0) $display("FAIL flush_drained: got %h expected %h", count, 24'h0); else passed++;
  endtask

  task automatic test_finished();
    push_one(7, 32'h77);
    src_finished = 1'b1;
    tick();
    total++; if (finished !== 1'b0) $display("FAIL finished_busy: got %b expected 0", finished); else passed++;
    deq_ready = 8'h80;
    tick();
    deq_ready = 8'h00;
    total++; if (finished !== 1'b0) $display("FAIL finished_lag: got %b expected 0", finished); else passed++;
    tick();
    total++; if (finished !== 1'b1) $display("FAIL finished_set: got %b expected 1", finished); else passed++;
    src_finished = 1'b0;
    tick();
    total++; if (finished !== 1'b0) $display("FAIL finished_clear: got %b expected 0", finished); else passed++;
  endtask

  task automatic test_reset_midstream();
    push_one(0, 32'h40);
    push_one(4, 32'h41);
    push_one(4, 32'h42);
    total++; if (deq_valid !== 8'h11) $display("FAIL midreset_pre: got %h expected %h", deq_valid, 8'h11); else passed++;
    reset = 1'b1;
    tick();
    total++; if (deq_valid !== 8'h00) $display("FAIL midreset_valid: got %h expected %h", deq_valid, 8'h00); else passed++;
    total++; if (count !== 24'h0) $display("FAIL midreset_count: got %h expected %h", count, 24'h0); else passed++;
    reset = 1'b0;
    push_one(4, 32'h44);
    total++; if (cnt_of(4) !== 3'd1) $display("FAIL midreset_repush_count: got %0d expected 1", cnt_of(4)); else passed++;
    total++; if (head_of(4) !== make_entry(32'h44)) $display("FAIL midreset_repush_data: got pc %h expected %h", head_of(4).pc, 32'h44); else passed++;
  endtask

  initial begin
    reset        = 1'b1;
    enq_valid    = 1'b0;
    enq_wid      = '0;
    enq_bits     = '0;
    flush        = '0;
    deq_ready    = '0;
    src_finished = 1'b0;
    #1;
    test_reset();
    test_push();
    test_full();
    test_wrap();
    test_flush();
    test_finished();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
